// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_gen
// Brief   : Parametrised raster timing generator with pixel-clock divider,
//           line/frame strobes, frame counter and look-ahead fetch coordinate.
// Revision: 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int SYNC_POL  = 0,
  parameter int CLK_DIV   = 2,
  parameter int LOOKAHEAD = 0,
  parameter int COUNT_W   = 10,
  parameter int FRAME_W   = 8
) (
  input  logic               clock,
  input  logic               clear,
  output logic               hSync,
  output logic               vSync,
  output logic               bright,
  output logic [COUNT_W-1:0] hCount,
  output logic [COUNT_W-1:0] vCount,
  output logic               pixelTick,
  output logic               lineStart,
  output logic               frameStart,
  output logic [FRAME_W-1:0] frameCount,
  output logic [COUNT_W-1:0] fetchX,
  output logic [COUNT_W-1:0] fetchY,
  output logic               fetchValid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   c_DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COUNT_W-1:0] c_H_LAST   = COUNT_W'(H_TOTAL - 1);
  localparam logic [COUNT_W-1:0] c_V_LAST   = COUNT_W'(V_TOTAL - 1);
  localparam logic [COUNT_W-1:0] c_H_ACT    = COUNT_W'(H_ACTIVE);
  localparam logic [COUNT_W-1:0] c_V_ACT    = COUNT_W'(V_ACTIVE);
  localparam logic [COUNT_W-1:0] c_HS_FIRST = COUNT_W'(H_ACTIVE + H_FP);
  localparam logic [COUNT_W-1:0] c_HS_LAST  = COUNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COUNT_W-1:0] c_VS_FIRST = COUNT_W'(V_ACTIVE + V_FP);
  localparam logic [COUNT_W-1:0] c_VS_LAST  = COUNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic               c_SYNC_ON  = 1'(SYNC_POL);
  // Fetch position starts LOOKAHEAD steps past the pre-roll position (last pixel of frame).
  localparam logic [COUNT_W-1:0] c_FH_RST   = (LOOKAHEAD == 0) ? c_H_LAST : COUNT_W'(LOOKAHEAD - 1);
  localparam logic [COUNT_W-1:0] c_FV_RST   = (LOOKAHEAD == 0) ? c_V_LAST : '0;

  logic [DIV_W-1:0]   r_div;
  logic [COUNT_W-1:0] r_h, r_v, r_fh, r_fv;
  logic               r_first;
  logic               r_hsync, r_vsync, r_bright, r_tick, r_line, r_frame, r_fvalid;
  logic [COUNT_W-1:0] r_hcount, r_vcount, r_fx, r_fy;
  logic [FRAME_W-1:0] r_fcount;

  logic               w_step, w_h_wrap, w_frame_wrap, w_fh_wrap;
  logic [COUNT_W-1:0] w_h_nxt, w_v_nxt, w_fh_nxt, w_fv_nxt;

  always_comb begin
    w_step       = (r_div == c_DIV_LAST);
    w_h_wrap     = (r_h == c_H_LAST);
    w_frame_wrap = w_h_wrap && (r_v == c_V_LAST);
    w_h_nxt      = w_h_wrap ? '0 : r_h + COUNT_W'(1);
    w_v_nxt      = r_v;
    if (w_h_wrap) w_v_nxt = (r_v == c_V_LAST) ? '0 : r_v + COUNT_W'(1);
    w_fh_wrap    = (r_fh == c_H_LAST);
    w_fh_nxt     = w_fh_wrap ? '0 : r_fh + COUNT_W'(1);
    w_fv_nxt     = r_fv;
    if (w_fh_wrap) w_fv_nxt = (r_fv == c_V_LAST) ? '0 : r_fv + COUNT_W'(1);
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_div    <= '0;
      r_h      <= c_H_LAST;
      r_v      <= c_V_LAST;
      r_fh     <= c_FH_RST;
      r_fv     <= c_FV_RST;
      r_first  <= 1'b1;
      r_hsync  <= ~c_SYNC_ON;
      r_vsync  <= ~c_SYNC_ON;
      r_bright <= 1'b0;
      r_tick   <= 1'b0;
      r_line   <= 1'b0;
      r_frame  <= 1'b0;
      r_hcount <= '0;
      r_vcount <= '0;
      r_fx     <= '0;
      r_fy     <= '0;
      r_fvalid <= 1'b0;
      r_fcount <= '0;
    end else begin
      r_div   <= w_step ? '0 : r_div + DIV_W'(1);
      r_tick  <= w_step;
      r_line  <= 1'b0;
      r_frame <= 1'b0;
      if (w_step) begin
        r_h      <= w_h_nxt;
        r_v      <= w_v_nxt;
        r_fh     <= w_fh_nxt;
        r_fv     <= w_fv_nxt;
        r_first  <= 1'b0;
        r_hcount <= w_h_nxt;
        r_vcount <= w_v_nxt;
        r_hsync  <= (w_h_nxt >= c_HS_FIRST && w_h_nxt <= c_HS_LAST) ? c_SYNC_ON : ~c_SYNC_ON;
        r_vsync  <= (w_v_nxt >= c_VS_FIRST && w_v_nxt <= c_VS_LAST) ? c_SYNC_ON : ~c_SYNC_ON;
        r_bright <= (w_h_nxt < c_H_ACT) && (w_v_nxt < c_V_ACT);
        r_line   <= w_h_wrap;
        r_frame  <= w_frame_wrap;
        r_fx     <= w_fh_nxt;
        r_fy     <= w_fv_nxt;
        r_fvalid <= (w_fh_nxt < c_H_ACT) && (w_fv_nxt < c_V_ACT);
        // The pre-roll step into (0,0) opens frame 0 rather than finishing one.
        if (w_frame_wrap && !r_first) r_fcount <= r_fcount + FRAME_W'(1);
      end
    end
  end

  assign hSync      = r_hsync;
  assign vSync      = r_vsync;
  assign bright     = r_bright;
  assign hCount     = r_hcount;
  assign vCount     = r_vcount;
  assign pixelTick  = r_tick;
  assign lineStart  = r_line;
  assign frameStart = r_frame;
  assign frameCount = r_fcount;
  assign fetchX     = r_fx;
  assign fetchY     = r_fy;
  assign fetchValid = r_fvalid;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_timing_gen
// Brief   : Self-checking bench; three configurations against a linear-index model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  typedef struct {
    int h, v, hs, vs, br, fc, tick, ls, fs, fx, fy, fv;
  } exp_t;

  logic clk = 1'b0;
  logic clr_ds = 1'b1;
  logic clr_p  = 1'b1;
  int   cyc_ds, cyc_p;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  // Rising edges seen since the respective clear was released.
  always @(posedge clk or posedge clr_ds)
    if (clr_ds) cyc_ds <= 0; else cyc_ds <= cyc_ds + 1;
  always @(posedge clk or posedge clr_p)
    if (clr_p) cyc_p <= 0; else cyc_p <= cyc_p + 1;

  logic       d_hs, d_vs, d_br, d_pt, d_ls, d_fs, d_fv;
  logic [9:0] d_h, d_v, d_fx, d_fy;
  logic [7:0] d_fc;
  logic       s_hs, s_vs, s_br, s_pt, s_ls, s_fs, s_fv;
  logic [9:0] s_h, s_v, s_fx, s_fy;
  logic [1:0] s_fc;
  logic       p_hs, p_vs, p_br, p_pt, p_ls, p_fs, p_fv;
  logic [9:0] p_h, p_v, p_fx, p_fy;
  logic [7:0] p_fc;

  vga_timing_gen #(.LOOKAHEAD(2)) uDef (
    .clock(clk), .clear(clr_ds), .hSync(d_hs), .vSync(d_vs), .bright(d_br),
    .hCount(d_h), .vCount(d_v), .pixelTick(d_pt), .lineStart(d_ls), .frameStart(d_fs),
    .frameCount(d_fc), .fetchX(d_fx), .fetchY(d_fy), .fetchValid(d_fv));

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2), .V_ACTIVE(3), .V_FP(1),
                   .V_SYNC(1), .V_BP(1), .CLK_DIV(1), .LOOKAHEAD(3), .FRAME_W(2)) uSmall (
    .clock(clk), .clear(clr_ds), .hSync(s_hs), .vSync(s_vs), .bright(s_br),
    .hCount(s_h), .vCount(s_v), .pixelTick(s_pt), .lineStart(s_ls), .frameStart(s_fs),
    .frameCount(s_fc), .fetchX(s_fx), .fetchY(s_fy), .fetchValid(s_fv));

  vga_timing_gen #(.H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(4), .V_ACTIVE(12), .V_FP(1),
                   .V_SYNC(2), .V_BP(2), .SYNC_POL(1), .CLK_DIV(3), .LOOKAHEAD(0)) uPol (
    .clock(clk), .clear(clr_p), .hSync(p_hs), .vSync(p_vs), .bright(p_br),
    .hCount(p_h), .vCount(p_v), .pixelTick(p_pt), .lineStart(p_ls), .frameStart(p_fs),
    .frameCount(p_fc), .fetchX(p_fx), .fetchY(p_fy), .fetchValid(p_fv));

  // Expected outputs from the number of pixel steps taken since clear fell.
  function automatic exp_t model(input int cyc, input int div, input int ha, input int hf,
                                 input int hsy, input int hb, input int va, input int vf,
                                 input int vsy, input int vb, input int pol, input int la,
                                 input int fw);
    exp_t e;
    int ht, vt, tot, k, n, f;
    ht = ha + hf + hsy + hb;
    vt = va + vf + vsy + vb;
    tot = ht * vt;
    k = cyc / div;
    e = '{default: 0};
    e.hs = (pol == 0) ? 1 : 0;
    e.vs = e.hs;
    if (k > 0) begin
      n = (k - 1) % tot;
      e.h = n % ht;
      e.v = n / ht;
      e.hs = (e.h >= ha + hf && e.h < ha + hf + hsy) ? pol : 1 - pol;
      e.vs = (e.v >= va + vf && e.v < va + vf + vsy) ? pol : 1 - pol;
      e.br = (e.h < ha && e.v < va) ? 1 : 0;
      e.fc = ((k - 1) / tot) % (1 << fw);
      e.tick = (cyc % div == 0) ? 1 : 0;
      e.ls = (e.tick == 1 && e.h == 0) ? 1 : 0;
      e.fs = (e.ls == 1 && e.v == 0) ? 1 : 0;
      f = (n + la) % tot;
      e.fx = f % ht;
      e.fy = f / ht;
      e.fv = (e.fx < ha && e.fy < va) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic cmp(input string nm, input exp_t e, input logic [31:0] h, input logic [31:0] v,
                     input logic hs, input logic vs, input logic br, input logic [31:0] fc,
                     input logic pt, input logic ls, input logic fs, input logic [31:0] fx,
                     input logic [31:0] fy, input logic fv);
    chk({nm, ".hCount"}, h, e.h);          chk({nm, ".vCount"}, v, e.v);
    chk({nm, ".hSync"}, {31'd0, hs}, e.hs); chk({nm, ".vSync"}, {31'd0, vs}, e.vs);
    chk({nm, ".bright"}, {31'd0, br}, e.br); chk({nm, ".frameCount"}, fc, e.fc);
    chk({nm, ".pixelTick"}, {31'd0, pt}, e.tick);
    chk({nm, ".lineStart"}, {31'd0, ls}, e.ls);
    chk({nm, ".frameStart"}, {31'd0, fs}, e.fs);
    chk({nm, ".fetchX"}, fx, e.fx);        chk({nm, ".fetchY"}, fy, e.fy);
    chk({nm, ".fetchValid"}, {31'd0, fv}, e.fv);
  endtask

  task automatic check_all();
    cmp("def", model(cyc_ds, 2, 640, 16, 96, 48, 480, 10, 2, 33, 0, 2, 8),
        d_h, d_v, d_hs, d_vs, d_br, d_fc, d_pt, d_ls, d_fs, d_fx, d_fy, d_fv);
    cmp("small", model(cyc_ds, 1, 4, 1, 1, 2, 3, 1, 1, 1, 0, 3, 2),
        s_h, s_v, s_hs, s_vs, s_br, s_fc, s_pt, s_ls, s_fs, s_fx, s_fy, s_fv);
    cmp("pol", model(cyc_p, 3, 20, 2, 3, 4, 12, 1, 2, 2, 1, 0, 8),
        p_h, p_v, p_hs, p_vs, p_br, p_fc, p_pt, p_ls, p_fs, p_fx, p_fy, p_fv);
  endtask

  initial begin
    int rel_p, hold, s_fs_cnt;
    int s_fc_seq[$];
    bit found;

    // Reset state with both clears held for a random interval.
    repeat ($urandom_range(3, 9)) begin
      @(negedge clk);
      check_all();
    end
    rel_p = $urandom_range(0, 40);
    clr_ds = 1'b0;

    // Free run until the default instance displays (798,5).
    s_fs_cnt = 0;
    found = 1'b0;
    for (int i = 0; i < 12000 && !found; i++) begin
      if (i == rel_p) clr_p = 1'b0;
      @(negedge clk);
      check_all();
      if (cyc_ds >= 1 && cyc_ds <= 240 && s_fs === 1'b1) begin
        s_fs_cnt++;
        s_fc_seq.push_back(int'(s_fc));
      end
      if (d_h == 10'd798 && d_v == 10'd5) found = 1'b1;
    end
    chk("def.reach_798_5", {31'd0, found}, 1);
    chk("def.la_fetchX", d_fx, 0);
    chk("def.la_fetchY", d_fy, 6);
    chk("def.la_fetchValid", {31'd0, d_fv}, 1);
    chk("small.frameStart_count", s_fs_cnt, 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("small.fc_seq%0d", i), (i < s_fc_seq.size()) ? s_fc_seq[i] : -1, i % 4);

    // Mid-frame clear on the active-high-sync instance.
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      check_all();
      if (p_h == 10'd10 && p_v == 10'd7 && p_fc != 8'd0) found = 1'b1;
    end
    chk("pol.reach_10_7", {31'd0, found}, 1);
    clr_p = 1'b1;
    hold = $urandom_range(1, 3);
    repeat (hold) begin
      @(negedge clk);
      check_all();
    end
    chk("pol.clear_fc", p_fc, 0);
    chk("pol.clear_hSync", {31'd0, p_hs}, 0);
    chk("pol.clear_hCount", p_h, 0);
    clr_p = 1'b0;
    repeat (3) @(negedge clk);
    chk("pol.restart_frameStart", {31'd0, p_fs}, 1);
    chk("pol.restart_fc", p_fc, 0);
    repeat (2 * 1479 + 50) begin
      @(negedge clk);
      check_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
